// File: rtl/iir_out_capture.sv
// ---------------------------------------------------------------------------
// iir_out_capture
// Captures one frame of IIR filter output samples into an address-indexed
// buffer.  Each buffer entry carries a "written" bit so unwritten entries read
// back as zero and duplicate writes can be detected.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous re-arm: empties the buffer, clears flags
//   in_valid          filter output valid
//   in_stable         filter settled; samples are only taken when high
//   in_addr, in_data  sample index and signed sample value
//   filter_done       filter finished the frame (ends capture)
//   rd_en, rd_addr    readout request, result one cycle later
//   rd_data           stored sample (0 when the entry was never written)
//   rd_written        entry at rd_addr holds a captured sample
//   rd_valid          one-cycle pulse qualifying rd_data / rd_written
//   captured_cnt      number of unique addresses written (saturates at DEPTH)
//   capture_done      frame complete
//   overwrite_err     sticky: an address was written twice
//   late_err          sticky: a sample arrived after the frame completed
// ---------------------------------------------------------------------------
module iir_out_capture #(
  parameter int DW    = 16,
  parameter int AW    = 11,
  parameter int DEPTH = 2048
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic                 in_stable,
  input  logic [AW-1:0]        in_addr,
  input  logic signed [DW-1:0] in_data,
  input  logic                 filter_done,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_written,
  output logic                 rd_valid,
  output logic [AW:0]          captured_cnt,
  output logic                 capture_done,
  output logic                 overwrite_err,
  output logic                 late_err
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [DW-1:0]     mem [DEPTH];
  logic [DEPTH-1:0]  written;

  logic              sample_ok;   // in_valid & in_stable
  logic              accept;      // sample is stored this cycle
  logic              late;        // sample offered after frame completion
  logic              addr_new;    // target entry not yet written
  logic              cnt_inc;
  logic [AW:0]       cnt_next;

  // Next-state and write-qualification logic
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    late       = 1'b0;
    sample_ok  = in_valid & in_stable;
    addr_new   = ~written[in_addr];

    // The first settled sample both leaves ARMED and is stored, so no
    // sample is lost at the start of a frame.
    case (state)
      ARMED: begin
        if (sample_ok) begin
          accept = 1'b1;
        end else begin
          accept = 1'b0;
        end
      end
      CAPTURE: begin
        accept = sample_ok;
      end
      DONE: begin
        late = sample_ok;
      end
      default: begin
        accept = 1'b0;
        late   = 1'b0;
      end
    endcase

    // Saturating guard keeps the count from ever wrapping
    cnt_inc = accept & addr_new & (captured_cnt != DEPTH_CNT);
    if (cnt_inc) begin
      cnt_next = captured_cnt + CNT_ONE;
    end else begin
      cnt_next = captured_cnt;
    end

    case (state)
      ARMED: begin
        if (accept && (cnt_next == DEPTH_CNT)) begin
          state_next = DONE;
        end else if (accept) begin
          state_next = CAPTURE;
        end else begin
          state_next = ARMED;
        end
      end
      CAPTURE: begin
        if (filter_done || (cnt_next == DEPTH_CNT)) begin
          state_next = DONE;
        end else begin
          state_next = CAPTURE;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = ARMED;
      end
    endcase

    // clear wins over everything happening in the same cycle
    if (clear) begin
      state_next = ARMED;
      accept     = 1'b0;
      late       = 1'b0;
      cnt_inc    = 1'b0;
      cnt_next   = captured_cnt;
    end else begin
      state_next = state_next;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARMED;
    end else begin
      state <= state_next;
    end
  end

  // Written bits, unique-address count and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written       <= {DEPTH{1'b0}};
      captured_cnt  <= {(AW+1){1'b0}};
      capture_done  <= 1'b0;
      overwrite_err <= 1'b0;
      late_err      <= 1'b0;
    end else if (clear) begin
      written       <= {DEPTH{1'b0}};
      captured_cnt  <= {(AW+1){1'b0}};
      capture_done  <= 1'b0;
      overwrite_err <= 1'b0;
      late_err      <= 1'b0;
    end else begin
      if (accept) begin
        written[in_addr] <= 1'b1;
      end else begin
        written <= written;
      end
      captured_cnt <= cnt_next;
      // Registered from the next state so it rises the cycle after the
      // completing edge and holds for as long as the block stays in DONE.
      capture_done <= (state_next == DONE);
      if (accept && !addr_new) begin
        overwrite_err <= 1'b1;
      end else begin
        overwrite_err <= overwrite_err;
      end
      if (late) begin
        late_err <= 1'b1;
      end else begin
        late_err <= late_err;
      end
    end
  end

  // Sample storage; contents are masked by the written bits, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[in_addr] <= in_data;
    end else begin
      mem[in_addr] <= mem[in_addr];
    end
  end

  // Readout path: samples memory before this edge's write (read-first)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data    <= {DW{1'b0}};
      rd_written <= 1'b0;
      rd_valid   <= 1'b0;
    end else if (clear) begin
      rd_data    <= {DW{1'b0}};
      rd_written <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_written <= written[rd_addr];
        rd_data    <= written[rd_addr] ? mem[rd_addr] : {DW{1'b0}};
      end else begin
        rd_written <= rd_written;
        rd_data    <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_iir_out_capture.sv
// ---------------------------------------------------------------------------
// tb_iir_out_capture
// Directed stimulus with a frame-level reference model: the model keeps the
// captured samples in plain arrays and decides phase changes from the frame
// rules; every falling edge the DUT outputs are compared against it.  A set
// of hand-computed literal expectations pins the model itself.
// ---------------------------------------------------------------------------
module tb_iir_out_capture;

  localparam int DW    = 16;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  localparam int PH_ARMED   = 0;
  localparam int PH_CAPTURE = 1;
  localparam int PH_DONE    = 2;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic          clear       = 1'b0;
  logic          in_valid    = 1'b0;
  logic          in_stable   = 1'b0;
  logic [AW-1:0] in_addr     = '0;
  logic [DW-1:0] in_data     = '0;
  logic          filter_done = 1'b0;
  logic          rd_en       = 1'b0;
  logic [AW-1:0] rd_addr     = '0;
  logic [DW-1:0] rd_data;
  logic          rd_written;
  logic          rd_valid;
  logic [AW:0]   captured_cnt;
  logic          capture_done;
  logic          overwrite_err;
  logic          late_err;

  int checks = 0;
  int errors = 0;

  iir_out_capture #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_stable    (in_stable),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .filter_done  (filter_done),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_written   (rd_written),
    .rd_valid     (rd_valid),
    .captured_cnt (captured_cnt),
    .capture_done (capture_done),
    .overwrite_err(overwrite_err),
    .late_err     (late_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_wr  [DEPTH];
  int            m_phase;
  int            m_cnt;
  bit            m_ovf, m_late, m_done;
  bit            m_rvalid, m_rwritten;
  logic [DW-1:0] m_rdata;

  task automatic model_empty();
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
    m_phase = PH_ARMED; m_cnt = 0;
    m_ovf = 1'b0; m_late = 1'b0; m_done = 1'b0;
    m_rvalid = 1'b0; m_rwritten = 1'b0; m_rdata = '0;
  endtask

  task automatic model_edge();
    int  start_phase;
    bit  settled;
    if (!rst_n || clear) begin
      model_empty();
      return;
    end
    start_phase = m_phase;
    // reads see the frame contents as they were before this edge
    m_rvalid = rd_en;
    if (rd_en) begin
      m_rwritten = m_wr[rd_addr];
      m_rdata    = m_wr[rd_addr] ? m_mem[rd_addr] : '0;
    end
    settled = in_valid && in_stable;
    if (start_phase == PH_DONE) begin
      if (settled) m_late = 1'b1;
    end else begin
      if (settled) begin
        if (m_wr[in_addr]) m_ovf = 1'b1;
        else begin
          m_wr[in_addr] = 1'b1;
          m_cnt++;
        end
        m_mem[in_addr] = in_data;
        m_phase = PH_CAPTURE;
      end
      if ((start_phase == PH_CAPTURE && filter_done) || m_cnt == DEPTH) m_phase = PH_DONE;
    end
    m_done = (m_phase == PH_DONE);
  endtask

  initial begin
    model_empty();
    forever begin
      @(posedge clk or negedge rst_n);
      model_edge();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("cnt",      32'(captured_cnt),  32'(m_cnt));
      check("done",     32'(capture_done),  32'(m_done));
      check("ovf_err",  32'(overwrite_err), 32'(m_ovf));
      check("late_err", 32'(late_err),      32'(m_late));
      check("rd_valid", 32'(rd_valid),      32'(m_rvalid));
      if (m_rvalid) begin
        check("rd_data",    32'(rd_data),    32'(m_rdata));
        check("rd_written", 32'(rd_written), 32'(m_rwritten));
      end
    end
  end

  // ---------------- stimulus helpers (called at falling edge) ----------------
  task automatic wr(input int a, input int d, input bit stable);
    in_valid = 1'b1; in_stable = stable;
    in_addr = AW'(a); in_data = DW'(d);
    @(negedge clk);
    in_valid = 1'b0; in_stable = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_en = 1'b1; rd_addr = AW'(a);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    // power-on reset
    repeat (2) @(negedge clk);
    check("rst_cnt",   32'(captured_cnt), 32'd0);
    check("rst_rdata", 32'(rd_data),      32'd0);
    check("rst_done",  32'(capture_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // full frame: addr 0..2047, data = addr*3
    for (int a = 0; a < DEPTH; a++) begin
      if (a == DEPTH - 1) check("full_done_early", 32'(capture_done), 32'd0);
      wr(a, a * 3, 1'b1);
    end
    check("full_cnt",  32'(captured_cnt), 32'd2048);
    check("full_done", 32'(capture_done), 32'd1);
    rd(100);
    check("full_rd100", 32'(rd_data),    32'd300);
    check("full_wr100", 32'(rd_written), 32'd1);

    // unstable samples ignored, then stable ones captured
    pulse_clear();
    check("clr_cnt", 32'(captured_cnt), 32'd0);
    for (int a = 0; a < 20; a++) wr(a, 16'hA000 + a, a >= 10);
    check("stab_cnt", 32'(captured_cnt), 32'd10);
    rd(5);
    check("stab_rd5",   32'(rd_data),    32'd0);
    check("stab_wr5",   32'(rd_written), 32'd0);
    rd(15);
    check("stab_rd15",  32'(rd_data),    32'hA00F);
    check("stab_wr15",  32'(rd_written), 32'd1);

    // overwrite of the same address
    pulse_clear();
    wr(7, 16'h1234, 1'b1);
    wr(7, 16'hBEEF, 1'b1);
    check("ovw_cnt", 32'(captured_cnt),  32'd1);
    check("ovw_err", 32'(overwrite_err), 32'd1);
    rd(7);
    check("ovw_rd7", 32'(rd_data), 32'hBEEF);

    // filter_done ignored in ARMED, ends frame in CAPTURE, late writes rejected
    pulse_clear();
    filter_done = 1'b1; @(negedge clk); filter_done = 1'b0;
    @(negedge clk);
    check("fd_armed_done", 32'(capture_done), 32'd0);
    for (int i = 0; i < 50; i++) wr(200 + i, i, 1'b1);
    filter_done = 1'b1; @(negedge clk); filter_done = 1'b0;
    check("fd_done", 32'(capture_done), 32'd1);
    check("fd_cnt",  32'(captured_cnt), 32'd50);
    wr(211, 16'h7777, 1'b0);
    check("fd_unstable_late", 32'(late_err), 32'd0);
    wr(210, 16'hFFFF, 1'b1);
    check("fd_late", 32'(late_err), 32'd1);
    rd(210);
    check("fd_rd210", 32'(rd_data), 32'd10);

    // read-first on same-address read and write
    pulse_clear();
    wr(3, 16'h0011, 1'b1);
    rd_en = 1'b1; rd_addr = AW'(3);
    wr(3, 16'h0055, 1'b1);
    rd_en = 1'b0;
    check("rf_old", 32'(rd_data), 32'h0011);
    rd(3);
    check("rf_new", 32'(rd_data), 32'h0055);

    // clear mid-frame with concurrent write and read
    pulse_clear();
    for (int a = 40; a < 45; a++) wr(a, a, 1'b1);
    wr(40, 16'h0001, 1'b1);
    clear = 1'b1; rd_en = 1'b1; rd_addr = AW'(40);
    wr(45, 16'h4545, 1'b1);
    clear = 1'b0; rd_en = 1'b0;
    check("mclr_cnt",   32'(captured_cnt),  32'd0);
    check("mclr_ovf",   32'(overwrite_err), 32'd0);
    check("mclr_rdv",   32'(rd_valid),      32'd0);
    rd(45);
    check("mclr_wr45", 32'(rd_written), 32'd0);
    rd(40);
    check("mclr_wr40", 32'(rd_written), 32'd0);
    wr(46, 16'h0046, 1'b1);
    check("mclr_rearm", 32'(captured_cnt), 32'd1);

    // asynchronous reset pulse mid-frame
    for (int a = 50; a < 55; a++) wr(a, a, 1'b1);
    wr(50, 16'h0002, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cnt", 32'(captured_cnt),  32'd0);
    check("arst_ovf", 32'(overwrite_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(50);
    check("arst_wr50", 32'(rd_written), 32'd0);
    rd(46);
    check("arst_wr46", 32'(rd_written), 32'd0);
    wr(60, 16'h0060, 1'b1);
    check("arst_rearm", 32'(captured_cnt), 32'd1);
    rd(60);
    check("arst_rd60", 32'(rd_data), 32'h0060);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
